// File: rtl/tl_phase_sequencer_pkg.sv
// Shared definitions for the traffic-light phase sequencer.
//   state_t  : the eight light-cycle states S0..S7 (even = green/left, odd = yellow)
//   light_t  : light codes driven to the street lamp drivers
//   lights_t : the pair of light codes for street A and street B
//   decode_lights() : Moore decode from state to both streets' light codes
package tl_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // A through green
    S1 = 3'd1,  // A yellow after through
    S2 = 3'd2,  // A left turn
    S3 = 3'd3,  // A yellow after left
    S4 = 3'd4,  // B through green
    S5 = 3'd5,  // B yellow after through
    S6 = 3'd6,  // B left turn
    S7 = 3'd7   // B yellow after left
  } state_t;

  typedef enum logic [1:0] {
    L_GREEN  = 2'b00,
    L_YELLOW = 2'b01,
    L_LEFT   = 2'b10,
    L_RED    = 2'b11
  } light_t;

  typedef struct packed {
    light_t la;
    light_t lb;
  } lights_t;

  function automatic lights_t decode_lights(input state_t s);
    lights_t l;
    l.la = L_RED;
    l.lb = L_RED;
    case (s)
      S0: l.la = L_GREEN;
      S1: l.la = L_YELLOW;
      S2: l.la = L_LEFT;
      S3: l.la = L_YELLOW;
      S4: l.lb = L_GREEN;
      S5: l.lb = L_YELLOW;
      S6: l.lb = L_LEFT;
      S7: l.lb = L_YELLOW;
      default: begin
        l.la = L_RED;
        l.lb = L_RED;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Dwell counter for the phase sequencer: counts cycles spent in the current
// state. Clears on clr (state change), freezes when en is low, saturates at
// its all-ones value.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset, forces dwell to 0
//   en    : advance enable; when low the count holds
//   clr   : restart the count at 0 on this edge (state is changing)
//   dwell : cycles already spent in the current state
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] dwell
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= '0;
    end else if (en) begin
      if (clr) begin
        dwell <= '0;
      end else if (dwell != CNT_MAX) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_phase_sequencer.sv
// Timed phase sequencer for a four-approach intersection with left-turn
// phases. Walks S0..S7 with a minimum green, a maximum-green fairness cap,
// a fixed yellow time and skipping of left phases nobody is waiting for.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset (S0, dwell 0)
//   en    : advance enable; low freezes state and dwell, sensors ignored
//   Ta/Tal/Tb/Tbl : traffic sensors (A through, A left, B through, B left)
//   state : current state register {q2,q1,q0}
//   La/Lb : light codes for street A / street B
//   dwell : cycles already spent in the current state
module tl_phase_sequencer
  import tl_phase_sequencer_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             Ta,
  input  logic             Tal,
  input  logic             Tb,
  input  logic             Tbl,
  output logic [2:0]       state,
  output logic [1:0]       La,
  output logic [1:0]       Lb,
  output logic [CNT_W-1:0] dwell
);

  // Exit thresholds expressed as the dwell value seen in the last cycle.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);

  state_t  state_reg;
  state_t  state_next;
  logic    sensor;
  logic    leave;
  lights_t lights;

  // Successor state and the sensor that holds the current green/left phase.
  // For S1/S5 the successor depends on whether anyone waits for the left.
  always_comb begin
    sensor     = 1'b0;
    state_next = state_reg;
    case (state_reg)
      S0: begin sensor = Ta;  state_next = S1; end
      S1: state_next = Tal ? S2 : S4;
      S2: begin sensor = Tal; state_next = S3; end
      S3: state_next = S4;
      S4: begin sensor = Tb;  state_next = S5; end
      S5: state_next = Tbl ? S6 : S0;
      S6: begin sensor = Tbl; state_next = S7; end
      S7: state_next = S0;
      default: state_next = S0;
    endcase
  end

  // Odd states are yellow with a fixed dwell; even states hold while their
  // sensor is asserted, but the max-green cap overrides a busy sensor.
  always_comb begin
    leave = 1'b0;
    if (state_reg[0]) begin
      leave = (dwell == YEL_LAST);
    end else begin
      leave = ((dwell >= MIN_LAST) && !sensor) || (dwell == MAX_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S0;
    end else if (en && leave) begin
      state_reg <= state_next;
    end
  end

  // The timer is gated by the same enable, so a frozen cycle neither clears
  // nor advances the count.
  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (leave),
    .dwell (dwell)
  );

  assign lights = decode_lights(state_reg);
  assign state  = state_reg;
  assign La     = lights.la;
  assign Lb     = lights.lb;

endmodule

// File: tb/tb_tl_phase_sequencer.sv
// Self-checking bench for tl_phase_sequencer: directed scenarios for reset,
// the idle cycle, max-green cap, left phase, enable freeze and mid-phase
// reset, followed by randomized traffic against a behavioural model.
module tb_tl_phase_sequencer;

  localparam int CNT_W     = 8;
  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 16;
  localparam int YELLOW    = 3;

  logic             clk;
  logic             reset;
  logic             en;
  logic             Ta, Tal, Tb, Tbl;
  logic [2:0]       state;
  logic [1:0]       La, Lb;
  logic [CNT_W-1:0] dwell;

  int n_checks = 0;
  int n_pass   = 0;

  // Light codes per state, written straight from the light table.
  logic [1:0] exp_la [8] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [1:0] exp_lb [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};

  // Behavioural model: current phase and cycles already spent in it.
  int m_state;
  int m_dwell;

  tl_phase_sequencer #(
    .CNT_W     (CNT_W),
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YELLOW    (YELLOW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .Ta    (Ta),
    .Tal   (Tal),
    .Tb    (Tb),
    .Tbl   (Tbl),
    .state (state),
    .La    (La),
    .Lb    (Lb),
    .dwell (dwell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: through the active edge, back to the sampling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Short reset pulse entirely between edges (called just after a negedge).
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  function automatic void model_reset();
    m_state = 0;
    m_dwell = 0;
  endfunction

  // Advance the model by one enabled clock, from the phase rules.
  function automatic void model_step(input bit e, input bit ta, input bit tal,
                                     input bit tb, input bit tbl);
    bit [3:0] sens;
    int spent;
    bit go;
    sens  = {tbl, tb, tal, ta};
    spent = m_dwell + 1;
    if (!e) return;
    if (m_state % 2 == 0)
      go = (spent == MAX_GREEN) || (spent >= MIN_GREEN && !sens[m_state / 2]);
    else
      go = (spent == YELLOW);
    if (go) begin
      case (m_state)
        1:       m_state = tal ? 2 : 4;
        5:       m_state = tbl ? 6 : 0;
        default: m_state = (m_state + 1) % 8;
      endcase
      m_dwell = 0;
    end else if (m_dwell < (1 << CNT_W) - 1) begin
      m_dwell = m_dwell + 1;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
    #3;
    n_checks++;
    if (state !== 3'b000 || dwell !== '0 || La !== 2'b00 || Lb !== 2'b11) begin
      $display("FAIL reset_immediate: got state=%0d dwell=%0d La=%b Lb=%b, want 0/0/00/11",
               state, dwell, La, Lb);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (state !== 3'b000 || dwell !== '0) begin
      $display("FAIL reset_held: got state=%0d dwell=%0d, want 0/0", state, dwell);
    end else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_idle_cycle();
    int ph [4];
    int len [4];
    ph  = '{0, 1, 4, 5};
    len = '{MIN_GREEN, YELLOW, MIN_GREEN, YELLOW};
    for (int p = 0; p < 4; p++) begin
      for (int d = 0; d < len[p]; d++) begin
        n_checks++;
        if (state !== 3'(ph[p]) || dwell !== CNT_W'(d) ||
            La !== exp_la[ph[p]] || Lb !== exp_lb[ph[p]]) begin
          $display("FAIL idle_cycle: got state=%0d dwell=%0d La=%b Lb=%b, want state=%0d dwell=%0d",
                   state, dwell, La, Lb, ph[p], d);
        end else n_pass++;
        tick();
      end
    end
    n_checks++;
    if (state !== 3'd0 || dwell !== '0) begin
      $display("FAIL idle_wrap: got state=%0d dwell=%0d, want 0/0", state, dwell);
    end else n_pass++;
  endtask

  task automatic test_max_green();
    Ta = 1'b1;
    pulse_reset();
    for (int d = 0; d < MAX_GREEN; d++) begin
      n_checks++;
      if (state !== 3'd0 || dwell !== CNT_W'(d) || La !== 2'b00) begin
        $display("FAIL max_green_hold: got state=%0d dwell=%0d La=%b, want 0/%0d/00",
                 state, dwell, La, d);
      end else n_pass++;
      tick();
    end
    n_checks++;
    if (state !== 3'd1 || dwell !== '0 || La !== 2'b01 || Lb !== 2'b11) begin
      $display("FAIL max_green_exit: got state=%0d dwell=%0d La=%b Lb=%b, want 1/0/01/11",
               state, dwell, La, Lb);
    end else n_pass++;
  endtask

  task automatic test_left_phase();
    Ta = 1'b0;
    for (int d = 0; d < YELLOW; d++) begin
      n_checks++;
      if (state !== 3'd1 || dwell !== CNT_W'(d)) begin
        $display("FAIL left_s1: got state=%0d dwell=%0d, want 1/%0d", state, dwell, d);
      end else n_pass++;
      if (d == YELLOW - 1) Tal = 1'b1;
      tick();
    end
    for (int d = 0; d < 7; d++) begin
      n_checks++;
      if (state !== 3'd2 || dwell !== CNT_W'(d) || La !== 2'b10 || Lb !== 2'b11) begin
        $display("FAIL left_s2: got state=%0d dwell=%0d La=%b Lb=%b, want 2/%0d/10/11",
                 state, dwell, La, Lb, d);
      end else n_pass++;
      if (d == 6) Tal = 1'b0;
      tick();
    end
    for (int d = 0; d < YELLOW; d++) begin
      n_checks++;
      if (state !== 3'd3 || dwell !== CNT_W'(d) || La !== 2'b01) begin
        $display("FAIL left_s3: got state=%0d dwell=%0d La=%b, want 3/%0d/01",
                 state, dwell, La, d);
      end else n_pass++;
      tick();
    end
    n_checks++;
    if (state !== 3'd4 || dwell !== '0 || La !== 2'b11 || Lb !== 2'b00) begin
      $display("FAIL left_to_s4: got state=%0d dwell=%0d La=%b Lb=%b, want 4/0/11/00",
               state, dwell, La, Lb);
    end else n_pass++;
  endtask

  task automatic test_enable_hold();
    Tb = 1'b0;
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (state !== 3'd4 || dwell !== CNT_W'(2) || Lb !== 2'b00) begin
        $display("FAIL enable_hold: got state=%0d dwell=%0d Lb=%b, want 4/2/00",
                 state, dwell, Lb);
      end else n_pass++;
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd4 || dwell !== CNT_W'(3)) begin
      $display("FAIL enable_resume: got state=%0d dwell=%0d, want 4/3", state, dwell);
    end else n_pass++;
    tick();
    n_checks++;
    if (state !== 3'd5 || dwell !== '0 || Lb !== 2'b01) begin
      $display("FAIL enable_exit: got state=%0d dwell=%0d Lb=%b, want 5/0/01",
               state, dwell, Lb);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_phase();
    Tbl = 1'b1;
    repeat (YELLOW) tick();
    n_checks++;
    if (state !== 3'd6 || dwell !== '0) begin
      $display("FAIL reach_s6: got state=%0d dwell=%0d, want 6/0", state, dwell);
    end else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (state !== 3'd6 || dwell !== CNT_W'(5) || La !== 2'b11 || Lb !== 2'b10) begin
      $display("FAIL s6_dwell5: got state=%0d dwell=%0d La=%b Lb=%b, want 6/5/11/10",
               state, dwell, La, Lb);
    end else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || dwell !== '0 || La !== 2'b00 || Lb !== 2'b11) begin
      $display("FAIL reset_mid_phase: got state=%0d dwell=%0d La=%b Lb=%b, want 0/0/00/11",
               state, dwell, La, Lb);
    end else n_pass++;
    #1 reset = 1'b0;
    Tbl = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd0 || dwell !== CNT_W'(1)) begin
      $display("FAIL post_reset_count: got state=%0d dwell=%0d, want 0/1", state, dwell);
    end else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    pulse_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      // Sticky sensors so long queues (and the max-green cap) occur.
      if ($urandom_range(7) == 0) Ta  = ~Ta;
      if ($urandom_range(7) == 0) Tal = ~Tal;
      if ($urandom_range(7) == 0) Tb  = ~Tb;
      if ($urandom_range(7) == 0) Tbl = ~Tbl;
      en = ($urandom_range(7) != 0);
      if ($urandom_range(199) == 0) begin
        pulse_reset();
        model_reset();
      end
      @(posedge clk);
      model_step(en, Ta, Tal, Tb, Tbl);
      @(negedge clk);
      n_checks++;
      if (state !== 3'(m_state) || dwell !== CNT_W'(m_dwell) ||
          La !== exp_la[m_state] || Lb !== exp_lb[m_state]) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got state=%0d dwell=%0d La=%b Lb=%b, want state=%0d dwell=%0d La=%b Lb=%b",
                   i, state, dwell, La, Lb, m_state, m_dwell, exp_la[m_state], exp_lb[m_state]);
        // Resynchronise so a single divergence is not reported thousands of times.
        pulse_reset();
        model_reset();
      end else n_pass++;
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_cycle();
    test_max_green();
    test_left_phase();
    test_enable_hold();
    test_reset_mid_phase();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
